// File: rtl/byte_encode_stream.sv
`default_nettype none
// ============================================================================
// byte_encode_stream: Kyber ByteEncode_d packer for d = 1..12. Input beats
// carry several coefficients and are accepted with valid/ready. Output is
// packed little-endian into OUT_W-bit words, also with valid/ready.
// Revision: 1.0
// ============================================================================
module byte_encode_stream #(
  parameter int NCOEF    = 2,
  parameter int OUT_W    = 64,
  parameter int N_COEFFS = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [3:0]            i_d,
  output logic                  o_busy,
  input  logic [NCOEF*12-1:0]   i_coeffs,
  input  logic                  i_coeffs_valid,
  output logic                  o_coeffs_ready,
  output logic [OUT_W-1:0]      o_obytes,
  output logic                  o_obytes_valid,
  input  logic                  i_obytes_ready,
  output logic                  o_obytes_last,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int C_PACK_W = NCOEF * 12;
  localparam int C_ACC_W  = OUT_W + C_PACK_W;
  localparam int C_FILL_W = $clog2(C_ACC_W + 1);
  localparam int C_OW_LOG = $clog2(OUT_W);

  localparam logic [C_FILL_W-1:0] C_OUT_W_F   = C_FILL_W'(OUT_W);
  localparam logic [9:0]          C_NCOEFFS_W = 10'(N_COEFFS);
  localparam logic [9:0]          C_NCOEF_W   = 10'(NCOEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            d_q, d_d;
  logic [C_ACC_W-1:0]    acc_q, acc_d;
  logic [C_FILL_W-1:0]   fill_q, fill_d;
  logic [8:0]            coef_cnt_q, coef_cnt_d;
  logic [6:0]            word_cnt_q, word_cnt_d;
  logic [OUT_W-1:0]      obytes_q, obytes_d;
  logic                  ovalid_q, ovalid_d;
  logic                  olast_q, olast_d;
  logic                  err_q, err_d;

  logic [11:0]           w_mask;
  logic [C_PACK_W-1:0]   w_pack;
  logic [C_FILL_W-1:0]   w_beat_bits;
  logic [11:0]           w_stream_bits;
  logic [6:0]            w_last_idx;
  logic                  w_in_ready;
  logic                  w_in_acc;
  logic                  w_load;
  logic                  w_out_hs;
  logic [C_ACC_W-1:0]    w_base_acc;
  logic [C_FILL_W-1:0]   w_base_fill;
  logic [9:0]            w_cnt_sum;
  logic                  w_d_legal;

  // Each lane is masked to d bits and placed at lane*d inside the beat.
  always_comb begin
    w_mask = 12'((13'h1 << d_q) - 13'h1);
    w_pack = '0;
    for (int k = 0; k < NCOEF; k++) begin
      w_pack = w_pack | (C_PACK_W'(i_coeffs[12*k +: 12] & w_mask) << (k * int'(d_q)));
    end
  end

  assign w_beat_bits   = C_FILL_W'(NCOEF * int'(d_q));
  assign w_stream_bits = {d_q, 8'h00};
  assign w_last_idx    = 7'(w_stream_bits >> C_OW_LOG) - 7'd1;
  assign w_d_legal     = (i_d != 4'd0) && (i_d <= 4'd12);

  // Ready depends on registered state only, never on i_obytes_ready.
  assign w_in_ready  = (state_q == S_RUN) && (10'(coef_cnt_q) < C_NCOEFFS_W)
                     && (fill_q < C_OUT_W_F);
  assign w_in_acc    = w_in_ready && i_coeffs_valid;
  assign w_load      = (state_q == S_RUN) && (fill_q >= C_OUT_W_F)
                     && (!ovalid_q || i_obytes_ready);
  assign w_out_hs    = ovalid_q && i_obytes_ready;
  assign w_base_acc  = w_load ? (acc_q >> OUT_W) : acc_q;
  assign w_base_fill = w_load ? (fill_q - C_OUT_W_F) : fill_q;
  assign w_cnt_sum   = 10'(coef_cnt_q) + C_NCOEF_W;

  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    acc_d      = acc_q;
    fill_d     = fill_q;
    coef_cnt_d = coef_cnt_q;
    word_cnt_d = word_cnt_q;
    obytes_d   = obytes_q;
    ovalid_d   = ovalid_q;
    olast_d    = olast_q;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (w_d_legal) begin
            d_d        = i_d;
            acc_d      = '0;
            fill_d     = '0;
            coef_cnt_d = '0;
            word_cnt_d = '0;
            ovalid_d   = 1'b0;
            olast_d    = 1'b0;
            state_d    = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (w_load) begin
          obytes_d   = acc_q[OUT_W-1:0];
          ovalid_d   = 1'b1;
          olast_d    = (word_cnt_q == w_last_idx);
          word_cnt_d = word_cnt_q + 7'd1;
        end else if (w_out_hs) begin
          ovalid_d = 1'b0;
          olast_d  = 1'b0;
        end

        // A beat accepted alongside a load lands at the post-shift fill.
        if (w_in_acc) begin
          acc_d      = w_base_acc | (C_ACC_W'(w_pack) << w_base_fill);
          fill_d     = w_base_fill + w_beat_bits;
          coef_cnt_d = (w_cnt_sum >= C_NCOEFFS_W) ? 9'(C_NCOEFFS_W) : 9'(w_cnt_sum);
        end else begin
          acc_d  = w_base_acc;
          fill_d = w_base_fill;
        end

        if (w_out_hs && olast_q) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d  = S_IDLE;
        ovalid_d = 1'b0;
        olast_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      d_q        <= '0;
      acc_q      <= '0;
      fill_q     <= '0;
      coef_cnt_q <= '0;
      word_cnt_q <= '0;
      obytes_q   <= '0;
      ovalid_q   <= 1'b0;
      olast_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      coef_cnt_q <= coef_cnt_d;
      word_cnt_q <= word_cnt_d;
      obytes_q   <= obytes_d;
      ovalid_q   <= ovalid_d;
      olast_q    <= olast_d;
      err_q      <= err_d;
    end
  end

  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = (state_q == S_DONE);
  assign o_err          = err_q;
  assign o_coeffs_ready = w_in_ready;
  assign o_obytes       = obytes_q;
  assign o_obytes_valid = ovalid_q;
  assign o_obytes_last  = olast_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_encode_stream.sv
`default_nettype none
// ============================================================================
// tb_byte_encode_stream: directed vectors for byte_encode_stream
// (NCOEF=2, OUT_W=64) against a bit-level ByteEncode_d reference.
// Revision: 1.0
// ============================================================================
module tb_byte_encode_stream;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic [3:0]  i_d;
  logic        o_busy;
  logic [23:0] i_coeffs;
  logic        i_coeffs_valid;
  logic        o_coeffs_ready;
  logic [63:0] o_obytes;
  logic        o_obytes_valid;
  logic        i_obytes_ready;
  logic        o_obytes_last;
  logic        o_done;
  logic        o_err;

  int n_vec  = 0;
  int n_miss = 0;

  logic [11:0] coef [256];

  byte_encode_stream #(.NCOEF(2), .OUT_W(64), .N_COEFFS(256)) u_dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_d            (i_d),
    .o_busy         (o_busy),
    .i_coeffs       (i_coeffs),
    .i_coeffs_valid (i_coeffs_valid),
    .o_coeffs_ready (o_coeffs_ready),
    .o_obytes       (o_obytes),
    .o_obytes_valid (o_obytes_valid),
    .i_obytes_ready (i_obytes_ready),
    .o_obytes_last  (o_obytes_last),
    .o_done         (o_done),
    .o_err          (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"},   o_busy, 0);
    check_val({tag, "_cready"}, o_coeffs_ready, 0);
    check_val({tag, "_obytes"}, o_obytes, 0);
    check_val({tag, "_ovalid"}, o_obytes_valid, 0);
    check_val({tag, "_olast"},  o_obytes_last, 0);
    check_val({tag, "_done"},   o_done, 0);
    check_val({tag, "_err"},    o_err, 0);
  endtask

  // Runs one polynomial; stops early after stop_after words (handshake pending).
  task automatic run_poly(input int d, input int stall_pct, input int stop_after,
                          input bit use_const, input logic [63:0] cw);
    logic [3071:0] stream;
    logic [63:0]   expw;
    logic [63:0]   prev_word;
    logic          prev_last;
    bit            prev_stall;
    int idx, beats, words, total, cyc, fill;

    stream = '0;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < d; j++)
        stream[i*d + j] = coef[i][j];
    total = 256 * d / 64;
    idx = 0; beats = 0; words = 0; cyc = 0;
    prev_stall = 1'b0; prev_word = '0; prev_last = 1'b0;

    @(negedge clk);
    i_start = 1'b1;
    i_d     = 4'(d);
    @(negedge clk);
    i_start = 1'b0;
    check_val("busy_run", o_busy, 1);

    while (words < total && words < stop_after && cyc < 4000) begin
      if (prev_stall) begin
        check_val("stall_valid", o_obytes_valid, 1);
        check_val("stall_word",  o_obytes, prev_word);
        check_val("stall_last",  o_obytes_last, prev_last);
      end
      fill = beats * 2 * d - 64 * (words + (o_obytes_valid ? 1 : 0));
      check_val("cready", o_coeffs_ready, (fill < 64) && (beats * 2 < 256));
      check_val("done_early", o_done, 0);

      i_obytes_ready = ($urandom_range(99) >= stall_pct);
      if (idx < 256) begin
        i_coeffs_valid = 1'b1;
        for (int k = 0; k < 2; k++) i_coeffs[12*k +: 12] = coef[idx + k];
      end else begin
        i_coeffs_valid = 1'b0;
      end
      if (i_coeffs_valid && o_coeffs_ready) begin
        idx   += 2;
        beats += 1;
      end

      prev_stall = o_obytes_valid && !i_obytes_ready;
      prev_word  = o_obytes;
      prev_last  = o_obytes_last;
      if (o_obytes_valid && i_obytes_ready) begin
        expw = use_const ? cw : stream[words*64 +: 64];
        check_val("word", o_obytes, expw);
        check_val("last", o_obytes_last, (words == total - 1));
        words++;
      end
      cyc++;
      @(negedge clk);
    end
    i_coeffs_valid = 1'b0;

    if (cyc >= 4000) check_val("timeout", 1, 0);
    if (words >= total) begin
      check_val("word_count", words, total);
      check_val("done", o_done, 1);
      check_val("valid_after", o_obytes_valid, 0);
      @(negedge clk);
      check_val("done_pulse", o_done, 0);
      check_val("busy_end", o_busy, 0);
    end
  endtask

  task automatic bad_start(input logic [3:0] d, input string tag);
    @(negedge clk);
    i_start = 1'b1;
    i_d     = d;
    @(negedge clk);
    i_start = 1'b0;
    check_val({tag, "_err"},  o_err, 1);
    check_val({tag, "_busy"}, o_busy, 0);
    @(negedge clk);
    check_val({tag, "_err_off"}, o_err, 0);
    check_val({tag, "_idle"},    o_busy, 0);
    check_val({tag, "_novalid"}, o_obytes_valid, 0);
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_d = '0;
    i_coeffs = '0; i_coeffs_valid = 1'b0; i_obytes_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    i_rst = 1'b0;

    for (int i = 0; i < 256; i++) coef[i] = 12'(i % 16);
    run_poly(4, 0, 999, 1'b1, 64'hFEDC_BA98_7654_3210);

    for (int i = 0; i < 256; i++) coef[i] = 12'hFFF;
    run_poly(1, 0, 999, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_poly(11, 0, 999, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);

    for (int i = 0; i < 256; i++) coef[i] = 12'($urandom_range(4095));
    run_poly(12, 30, 999, 1'b0, '0);

    bad_start(4'd0, "d0");
    bad_start(4'd13, "d13");

    for (int i = 0; i < 256; i++) coef[i] = 12'($urandom_range(4095));
    run_poly(10, 0, 5, 1'b0, '0);
    i_rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    check_all_zero("midrst_hold");
    i_rst = 1'b0;

    for (int i = 0; i < 256; i++) coef[i] = 12'($urandom_range(4095));
    run_poly(5, 20, 999, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
